tx_frame_sequencer: RTL and testbench

Sequences serial transmission of a block of 4-bit words held in the 16x4 word ROM. It drives the ROM address and the bit-select of the downstream 4:1 bit multiplexer, and frames each word UART-style: start bit, 4 data bits LSB-first, stop bit. A host requests a burst with a start/busy/done handshake. This block replaces the free-running 64-step counter as the address/bit source in the transmitter core.

---
 rtl/tx_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// Burst sequencer for the serial transmitter: walks the word ROM and frames each 4-bit word
// as start bit, 4 data bits LSB-first, stop bit, with a start/busy/done host handshake.
module tx_frame_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic       hit,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] first_addr,
  input  logic [3:0] word_cnt,
  input  logic [3:0] rom_word,
  output logic [3:0] rom_addr,
  output logic [1:0] bit_sel,
  output logic       TX,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [1:0]        bit_q, bit_d;
  logic [3:0]        addr_q, addr_d;
  logic [3:0]        rem_q, rem_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_end;
  logic [1:0]        bit_nxt;

  assign div_end = (div_q == DivLast);
  assign bit_nxt = bit_q + 2'd1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          addr_d  = first_addr;
          rem_d   = word_cnt;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = 2'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (div_end) begin
          div_d   = '0;
          tx_d    = rom_word[0];
          bit_d   = 2'd0;
          state_d = StData;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StData: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q != 2'd3) begin
            bit_d = bit_nxt;
            tx_d  = rom_word[bit_nxt];
          end else begin
            tx_d    = 1'b1;
            state_d = StStop;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StStop: begin
        if (div_end) begin
          div_d = '0;
          if (rem_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            // Next frame follows immediately; address wraps naturally at 4 bits.
            addr_d  = addr_q + 4'd1;
            rem_d   = rem_q - 4'd1;
            bit_d   = 2'd0;
            tx_d    = 1'b0;
            state_d = StStart;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        bit_d   = 2'd0;
        tx_d    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any in-flight progress but keeps the ROM address.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      bit_d   = 2'd0;
      done_d  = 1'b0;
      div_d   = '0;
      addr_d  = addr_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge hit or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= 2'd0;
      addr_q  <= 4'd0;
      rem_q   <= 4'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign bit_sel  = bit_q;
  assign TX       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer: table-driven bursts, random bursts against a
// frame-arithmetic reference model, and hand-written abort / reset / re-start sequences.
module tb_tx_frame_sequencer;

  localparam int DIV = 4;
  localparam int FRAME = 6 * DIV;

  logic       hit;
  logic       clr;
  logic       start;
  logic       abort;
  logic [3:0] first_addr;
  logic [3:0] word_cnt;
  logic [3:0] rom_word;
  logic [3:0] rom_addr;
  logic [1:0] bit_sel;
  logic       TX;
  logic       busy;
  logic       done;

  logic [3:0] rom [16];

  int total;
  int bad;

  // Environment ROM: combinational lookup on the address the DUT presents.
  assign rom_word = rom[rom_addr];

  tx_frame_sequencer #(.DIV(DIV)) dut (
    .hit        (hit),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .word_cnt   (word_cnt),
    .rom_word   (rom_word),
    .rom_addr   (rom_addr),
    .bit_sel    (bit_sel),
    .TX         (TX),
    .busy       (busy),
    .done       (done)
  );

  initial hit = 1'b0;
  always #5 hit = ~hit;

  typedef struct {
    logic [3:0] first;
    logic [3:0] cnt;
    logic [3:0] rom3;
    int         busy_cycles;
    logic [3:0] final_addr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs k cycles after the accepting edge, from frame arithmetic alone.
  task automatic model(input logic [3:0] first, input logic [3:0] cnt, input int k,
                       output logic e_tx, output logic e_busy, output logic e_done,
                       output logic [3:0] e_addr, output int e_bit);
    int n, len, w, p;
    logic [3:0] data;
    n   = int'(cnt) + 1;
    len = FRAME * n;
    if (k < len) begin
      w      = k / FRAME;
      p      = (k % FRAME) / DIV;
      e_addr = 4'((int'(first) + w) % 16);
      data   = rom[e_addr];
      e_tx   = (p == 0) ? 1'b0 : (p <= 4) ? data[p-1] : 1'b1;
      e_bit  = (p == 0) ? 0 : (p <= 4) ? p - 1 : 3;
      e_busy = 1'b1;
      e_done = 1'b0;
    end else begin
      e_addr = 4'((int'(first) + n - 1) % 16);
      e_tx   = 1'b1;
      e_busy = (k == len);
      e_done = (k == len);
      e_bit  = (k == len) ? -1 : 0;
    end
  endtask

  // Runs one burst and checks every cycle; optionally re-pulses start at cycle restart_at.
  task automatic burst(input string tag, input logic [3:0] first, input logic [3:0] cnt,
                       input int restart_at, output int busy_n, output int done_n);
    logic e_tx, e_busy, e_done;
    logic [3:0] e_addr;
    int e_bit, len;
    len    = FRAME * (int'(cnt) + 1);
    busy_n = 0;
    done_n = 0;
    @(negedge hit);
    first_addr = first;
    word_cnt   = cnt;
    start      = 1'b1;
    @(negedge hit);
    start = 1'b0;
    for (int k = 0; k <= len + 2; k++) begin
      model(first, cnt, k, e_tx, e_busy, e_done, e_addr, e_bit);
      chk({tag, " tx"}, int'(TX), int'(e_tx));
      chk({tag, " busy"}, int'(busy), int'(e_busy));
      chk({tag, " done"}, int'(done), int'(e_done));
      chk({tag, " addr"}, int'(rom_addr), int'(e_addr));
      if (e_bit >= 0) chk({tag, " bit_sel"}, int'(bit_sel), e_bit);
      busy_n += int'(busy);
      done_n += int'(done);
      if (k == restart_at) begin
        start      = 1'b1;
        first_addr = ~first;
        word_cnt   = ~cnt;
      end else begin
        start = 1'b0;
      end
      @(negedge hit);
    end
    start = 1'b0;
  endtask

  vec_t vecs [4];
  int   busy_n, done_n, seen_done;

  initial begin
    total      = 0;
    bad        = 0;
    clr        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = 4'd0;
    word_cnt   = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);

    vecs[0] = '{first: 4'd3,  cnt: 4'd0,  rom3: 4'b1010, busy_cycles: 25,  final_addr: 4'd3};
    vecs[1] = '{first: 4'd15, cnt: 4'd1,  rom3: 4'b0011, busy_cycles: 49,  final_addr: 4'd0};
    vecs[2] = '{first: 4'd0,  cnt: 4'd15, rom3: 4'b0011, busy_cycles: 385, final_addr: 4'd15};
    vecs[3] = '{first: 4'd7,  cnt: 4'd2,  rom3: 4'b0011, busy_cycles: 73,  final_addr: 4'd9};

    // Reset state
    #12;
    chk("rst tx", int'(TX), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst addr", int'(rom_addr), 0);
    chk("rst bit_sel", int'(bit_sel), 0);
    @(negedge hit);
    clr = 1'b1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'(i);
      rom[3] = vecs[v].rom3;
      burst($sformatf("vec%0d", v), vecs[v].first, vecs[v].cnt, -1, busy_n, done_n);
      chk($sformatf("vec%0d busy_len", v), busy_n, vecs[v].busy_cycles);
      chk($sformatf("vec%0d done_pulses", v), done_n, 1);
      chk($sformatf("vec%0d final_addr", v), int'(rom_addr), int'(vecs[v].final_addr));
    end

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
      burst($sformatf("rnd%0d", r), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
            -1, busy_n, done_n);
      chk($sformatf("rnd%0d done_pulses", r), done_n, 1);
    end

    // start re-pulsed mid-frame is ignored; then a fresh start after done works
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    burst("busyprot", 4'd4, 4'd1, 10, busy_n, done_n);
    chk("busyprot busy_len", busy_n, 49);
    burst("after_done", 4'd9, 4'd0, -1, busy_n, done_n);
    chk("after_done busy_len", busy_n, 25);

    // Abort during the 2nd data bit
    @(negedge hit);
    first_addr = 4'd2;
    word_cnt   = 4'd3;
    start      = 1'b1;
    @(negedge hit);
    start = 1'b0;
    repeat (9) @(negedge hit);
    chk("abort pre bit_sel", int'(bit_sel), 1);
    abort = 1'b1;
    @(negedge hit);
    abort = 1'b0;
    chk("abort tx", int'(TX), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort bit_sel", int'(bit_sel), 0);
    chk("abort addr", int'(rom_addr), 2);
    seen_done = int'(done);
    repeat (FRAME * 4 + 4) begin
      @(negedge hit);
      seen_done += int'(done) + int'(busy);
    end
    chk("abort no done/busy after", seen_done, 0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge hit);
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", int'(busy), 0);
    chk("start+abort tx", int'(TX), 1);
    @(negedge hit);
    chk("start+abort busy later", int'(busy), 0);

    // Async reset in the STOP phase of the first frame
    first_addr = 4'd5;
    word_cnt   = 4'd2;
    start      = 1'b1;
    @(negedge hit);
    start = 1'b0;
    repeat (21) @(negedge hit);
    chk("pre-rst tx stop", int'(TX), 1);
    chk("pre-rst busy", int'(busy), 1);
    #2 clr = 1'b0;
    #1;
    chk("async rst tx", int'(TX), 1);
    chk("async rst busy", int'(busy), 0);
    chk("async rst addr", int'(rom_addr), 0);
    chk("async rst bit_sel", int'(bit_sel), 0);
    chk("async rst done", int'(done), 0);
    @(negedge hit);
    clr = 1'b1;
    burst("post_rst", 4'd11, 4'd1, -1, busy_n, done_n);
    chk("post_rst busy_len", busy_n, 49);
    chk("post_rst done_pulses", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
